// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit 7-segment scan with frame snapshot, per-slot blanking, zero suppression and digit mask.
module seg_scan_ctrl #(
  parameter int SCAN_DIV         = 50000,
  parameter int BLANK_CYCLES     = 500,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic       lz_en,
  input  logic [3:0] digit_mask,
  output logic [1:0] sel,
  output logic [3:0] cur_bcd,
  output logic [3:0] an,
  output logic       blank,
  output logic       frame_tick
);
  localparam int TW = $clog2(SCAN_DIV);
  localparam logic [3:0] AN_OFF = (ANODE_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;
  state_t r_state, w_nstate;
  logic [TW-1:0] r_timer, w_ntimer;
  logic [15:0] r_snap, w_nsnap;
  logic [1:0] w_nsel;
  logic [3:0] w_sup;
  logic w_last, w_tick, w_active, w_z3, w_z2, w_z1;
  assign w_last = r_timer == TW'(SCAN_DIV - 1);
  always_comb begin
    w_nsel = sel;
    w_ntimer = r_timer;
    w_nsnap = r_snap;
    w_tick = 1'b0;
    if (!en) begin
      w_nsel = 2'd0;
      w_ntimer = '0;
    end else if (r_state == S_IDLE || (w_last && sel == 2'd3)) begin
      w_nsel = 2'd0;
      w_ntimer = '0;
      w_nsnap = {bcd3, bcd2, bcd1, bcd0};
      w_tick = 1'b1;
    end else if (w_last) begin
      w_nsel = sel + 2'd1;
      w_ntimer = '0;
    end else begin
      w_ntimer = r_timer + 1'b1;
    end
    w_nstate = !en ? S_IDLE : (w_ntimer < TW'(BLANK_CYCLES) ? S_BLANK : S_ON);
  end
  // Suppression and anode decisions use the post-edge snapshot/sel so outputs stay registered.
  assign w_z3 = w_nsnap[15:12] == 4'd0;
  assign w_z2 = w_z3 && w_nsnap[11:8] == 4'd0;
  assign w_z1 = w_z2 && w_nsnap[7:4] == 4'd0;
  assign w_sup = lz_en ? {w_z3, w_z2, w_z1, 1'b0} : 4'b0000;
  assign w_active = w_nstate == S_ON && digit_mask[w_nsel] && !w_sup[w_nsel];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_snap <= '0;
      sel <= 2'd0;
      cur_bcd <= 4'd0;
      an <= AN_OFF;
      blank <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_timer <= w_ntimer;
      r_snap <= w_nsnap;
      sel <= w_nsel;
      cur_bcd <= (w_nstate == S_IDLE) ? 4'd0 : w_nsnap[{w_nsel, 2'b00} +: 4];
      an <= AN_OFF ^ (w_active ? (4'b0001 << w_nsel) : 4'b0000);
      blank <= !w_active;
      frame_tick <= w_tick;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed plus random stimulus against a frame-position reference model.
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, lz_en = 1'b0;
  logic [3:0] bcd0 = 0, bcd1 = 0, bcd2 = 0, bcd3 = 0, digit_mask = 4'hF;
  logic [1:0] sel;
  logic [3:0] cur_bcd, an;
  logic blank, frame_tick;
  int checks = 0, errors = 0;
  bit m_run = 0;
  int m_t = 0;
  logic [3:0] m_snap [4];

  seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .en(en), .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
    .lz_en(lz_en), .digit_mask(digit_mask), .sel(sel), .cur_bcd(cur_bcd), .an(an),
    .blank(blank), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0t got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Model: a frame is 32 cycles, slot = t/8, position in slot = t%8, first 2 positions blanked.
  task automatic step(input logic r, input logic e);
    int slot, pos;
    bit sup, act;
    logic [3:0] e_an;
    rst = r;
    en = e;
    @(posedge clk);
    if (r) m_run = 0;
    else if (!e) m_run = 0;
    else begin
      m_t = m_run ? (m_t + 1) % 32 : 0;
      m_run = 1;
      if (m_t == 0) begin
        m_snap[0] = bcd0; m_snap[1] = bcd1; m_snap[2] = bcd2; m_snap[3] = bcd3;
      end
    end
    slot = m_t / 8;
    pos = m_t % 8;
    sup = lz_en && slot > 0;
    for (int j = 1; j < 4; j++) if (j >= slot && m_snap[j] != 0) sup = 0;
    act = m_run && pos >= 2 && digit_mask[slot] && !sup;
    e_an = act ? (4'hF & ~(4'b0001 << slot)) : 4'hF;
    #1;
    chk("an", an, e_an);
    chk("blank", {3'b0, blank}, {3'b0, !act});
    chk("sel", {2'b0, sel}, m_run ? 4'(slot) : 4'd0);
    chk("cur_bcd", cur_bcd, m_run ? m_snap[slot] : 4'd0);
    chk("frame_tick", {3'b0, frame_tick}, {3'b0, m_run && m_t == 0});
  endtask

  task automatic run_to(input int t);
    for (int i = 0; i < 40 && !(m_run && m_t == t); i++) step(0, 1);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) m_snap[k] = 4'd0;
    step(1, 0);
    step(1, 0);
    {bcd3, bcd2, bcd1, bcd0} = 16'h4321;
    repeat (44) step(0, 1);
    bcd0 = 4'd9;
    repeat (60) step(0, 1);
    lz_en = 1'b1;
    {bcd3, bcd2, bcd1, bcd0} = 16'h0050;
    repeat (64) step(0, 1);
    {bcd3, bcd2, bcd1, bcd0} = 16'h0000;
    repeat (40) step(0, 1);
    lz_en = 1'b0;
    {bcd3, bcd2, bcd1, bcd0} = 16'h8765;
    digit_mask = 4'b0101;
    repeat (64) step(0, 1);
    digit_mask = 4'hF;
    {bcd3, bcd2, bcd1, bcd0} = 16'hA0F3;
    run_to(22);
    step(0, 0);
    step(0, 0);
    repeat (40) step(0, 1);
    run_to(22);
    step(1, 1);
    step(0, 0);
    repeat (40) step(0, 1);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) {bcd3, bcd2, bcd1, bcd0} = 16'($urandom);
      if ($urandom_range(7) == 0) {bcd3, bcd2} = 8'h00;
      if ($urandom_range(31) == 0) lz_en = 1'($urandom);
      if ($urandom_range(31) == 0) digit_mask = 4'($urandom);
      step($urandom_range(199) == 0, $urandom_range(79) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
